// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial link (serializer and deserializer).
package serial_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

  localparam int SER_WIDTH = 8;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: loads a word on the valid/ack handshake
// and shifts it out MSB-first, one bit per write_out strobe, pausing while
// the receiver reports busy.
module serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH
) (
  input  logic             clock_100KHZ,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             ack_out,
  input  logic             status_in,
  output logic             bit_out,
  output logic             write_out,
  output logic             busy_out,
  output logic [7:0]       word_count
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             ack_q, ack_d;
  logic             bit_q, bit_d;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
  logic [7:0]       count_q, count_d;

  // Next-state and registered-output logic; strobe and ack default low.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ack_d     = 1'b0;
    bit_d     = bit_q;
    write_d   = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          shift_d   = data_in;
          ack_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // A busy receiver freezes the datapath; bit_out keeps its last value.
        if (!status_in) begin
          bit_d     = shift_q[WIDTH-1];
          write_d   = 1'b1;
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        count_d = count_q + 8'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy reflects the state being entered so it tracks SHIFT/DONE exactly.
    busy_d = (state_d != IDLE);
  end

  // State register and datapath, cleared asynchronously.
  always_ff @(posedge clock_100KHZ or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ack_q     <= 1'b0;
      bit_q     <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ack_q     <= ack_d;
      bit_q     <= bit_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign ack_out    = ack_q;
  assign bit_out    = bit_q;
  assign write_out  = write_q;
  assign busy_out   = busy_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: a scoreboard reassembles the serial
// stream MSB-first and compares each word against the queue of sent words.
`timescale 1ns/1ps
module tb_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ack_out;
  logic       status_in;
  logic       bit_out;
  logic       write_out;
  logic       busy_out;
  logic [7:0] word_count;

  int vectors;
  int miscompares;
  int cyc;

  logic [7:0] exp_q[$];
  logic       bits[$];
  int         stamps[$];
  int         ack_stamps[$];
  logic [7:0] rx;
  int         rx_cnt;

  serializer #(.WIDTH(8)) dut (
    .clock_100KHZ(clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .ack_out     (ack_out),
    .status_in   (status_in),
    .bit_out     (bit_out),
    .write_out   (write_out),
    .busy_out    (busy_out),
    .word_count  (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: sample on the falling edge, reassemble words, check scoreboard.
  initial begin
    rx     = 8'h00;
    rx_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_cnt = 0;
      end else begin
        if (ack_out) ack_stamps.push_back(cyc);
        if (write_out) begin
          bits.push_back(bit_out);
          stamps.push_back(cyc);
          rx = {rx[6:0], bit_out};
          rx_cnt++;
          if (rx_cnt == 8) begin
            rx_cnt = 0;
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL scoreboard: received %h, expected none (queue empty)", rx);
            end else begin
              logic [7:0] e;
              e = exp_q.pop_front();
              if (rx !== e) begin
                miscompares++;
                $display("FAIL scoreboard: received %h, expected %h", rx, e);
              end
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy_out && guard < 200) begin
      tick();
      guard++;
    end
    if (busy_out) begin
      miscompares++;
      $display("FAIL %s: timeout waiting for busy_out low", name);
    end
  endtask

  task automatic wait_acks(input int target, input string name);
    int guard;
    guard = 0;
    while (ack_stamps.size() < target && guard < 200) begin
      tick();
      guard++;
    end
    if (ack_stamps.size() < target) begin
      miscompares++;
      $display("FAIL %s: timeout waiting for ack_out", name);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    status_in  = 1'b0;
    tick();
    tick();
    vectors += 5;
    if (ack_out !== 1'b0)    begin miscompares++; $display("FAIL reset_ack: got %b want 0", ack_out); end
    if (bit_out !== 1'b0)    begin miscompares++; $display("FAIL reset_bit: got %b want 0", bit_out); end
    if (write_out !== 1'b0)  begin miscompares++; $display("FAIL reset_write: got %b want 0", write_out); end
    if (busy_out !== 1'b0)   begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    if (word_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", word_count); end
    reset = 1'b0;
    tick();
  endtask

  // A5 with the receiver always ready: cycle-exact strobe/ack/busy timing.
  task automatic test_single_word();
    logic [7:0] w;
    logic exp_ack, exp_wr, exp_busy;
    w = 8'hA5;
    exp_q.push_back(w);
    data_in    = w;
    data_valid = 1'b1;
    tick();               // c=0: just after the load edge
    data_valid = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      exp_ack  = (c == 0);
      exp_wr   = (c >= 1 && c <= 8);
      exp_busy = (c <= 8);
      vectors += 3;
      if (ack_out !== exp_ack) begin
        miscompares++; $display("FAIL a5_ack c=%0d: got %b want %b", c, ack_out, exp_ack);
      end
      if (write_out !== exp_wr) begin
        miscompares++; $display("FAIL a5_write c=%0d: got %b want %b", c, write_out, exp_wr);
      end
      if (busy_out !== exp_busy) begin
        miscompares++; $display("FAIL a5_busy c=%0d: got %b want %b", c, busy_out, exp_busy);
      end
      if (exp_wr) begin
        vectors++;
        if (bit_out !== w[8-c]) begin
          miscompares++; $display("FAIL a5_bit c=%0d: got %b want %b", c, bit_out, w[8-c]);
        end
      end
      tick();
    end
    vectors++;
    if (word_count !== 8'd1) begin
      miscompares++; $display("FAIL a5_count: got %0d want 1", word_count);
    end
  endtask

  // C3 with the receiver busy for three cycles after the fourth bit.
  task automatic test_stall();
    int base, guard;
    logic [7:0] seq;
    base = bits.size();
    exp_q.push_back(8'hC3);
    data_in    = 8'hC3;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    guard = 0;
    while (bits.size() < base + 4 && guard < 50) begin
      tick();
      guard++;
    end
    status_in = 1'b1;
    repeat (3) tick();
    status_in = 1'b0;
    wait_idle("stall");
    tick();
    vectors++;
    if (bits.size() - base !== 8) begin
      miscompares++; $display("FAIL stall_strobes: got %0d want 8", bits.size() - base);
    end else begin
      seq = 8'h00;
      for (int i = 0; i < 8; i++) seq = {seq[6:0], bits[base+i]};
      vectors++;
      if (seq !== 8'hC3) begin
        miscompares++; $display("FAIL stall_seq: got %h want c3", seq);
      end
      for (int i = 1; i < 8; i++) begin
        int gap;
        gap = (i == 4) ? 4 : 1;
        vectors++;
        if (stamps[base+i] - stamps[base+i-1] !== gap) begin
          miscompares++;
          $display("FAIL stall_gap %0d: got %0d want %0d", i,
                   stamps[base+i] - stamps[base+i-1], gap);
        end
      end
    end
  endtask

  // data_valid held high across three words: minimum word period.
  task automatic test_back_to_back();
    logic [7:0] words[3];
    int a0;
    logic [7:0] wc0;
    words[0] = 8'h01; words[1] = 8'hFF; words[2] = 8'h80;
    a0  = ack_stamps.size();
    wc0 = word_count;
    for (int i = 0; i < 3; i++) exp_q.push_back(words[i]);
    data_in    = words[0];
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_acks(a0 + i + 1, "b2b");
      if (i < 2) data_in = words[i+1];
      else       data_valid = 1'b0;
    end
    wait_idle("b2b");
    tick();
    for (int i = 1; i < 3; i++) begin
      vectors++;
      if (ack_stamps.size() < a0 + 3) begin
        miscompares++; $display("FAIL b2b_ackcount: got %0d want %0d", ack_stamps.size() - a0, 3);
      end else if (ack_stamps[a0+i] - ack_stamps[a0+i-1] !== 10) begin
        miscompares++;
        $display("FAIL b2b_spacing %0d: got %0d want 10", i,
                 ack_stamps[a0+i] - ack_stamps[a0+i-1]);
      end
    end
    vectors += 2;
    if (word_count !== wc0 + 8'd3) begin
      miscompares++; $display("FAIL b2b_count: got %0d want %0d", word_count, wc0 + 8'd3);
    end
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size());
    end
  endtask

  // Asynchronous reset after the fifth bit of 3C: partial word discarded.
  task automatic test_reset_midword();
    int base, guard, nb, na;
    base = bits.size();
    exp_q.push_back(8'h3C);
    data_in    = 8'h3C;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    guard = 0;
    while (bits.size() < base + 5 && guard < 50) begin
      tick();
      guard++;
    end
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    vectors += 5;
    if (ack_out !== 1'b0)    begin miscompares++; $display("FAIL rst_mid_ack: got %b want 0", ack_out); end
    if (bit_out !== 1'b0)    begin miscompares++; $display("FAIL rst_mid_bit: got %b want 0", bit_out); end
    if (write_out !== 1'b0)  begin miscompares++; $display("FAIL rst_mid_write: got %b want 0", write_out); end
    if (busy_out !== 1'b0)   begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy_out); end
    if (word_count !== 8'd0) begin miscompares++; $display("FAIL rst_mid_count: got %0d want 0", word_count); end
    tick();
    tick();
    reset = 1'b0;
    nb = bits.size();
    na = ack_stamps.size();
    repeat (20) tick();
    vectors += 2;
    if (bits.size() !== nb) begin
      miscompares++; $display("FAIL rst_mid_strobes: got %0d want 0", bits.size() - nb);
    end
    if (ack_stamps.size() !== na) begin
      miscompares++; $display("FAIL rst_mid_acks: got %0d want 0", ack_stamps.size() - na);
    end
  endtask

  // Twenty random words with random receiver stalls, checked by scoreboard.
  task automatic test_random_loopback();
    logic [7:0] w;
    int a0;
    for (int i = 0; i < 20; i++) begin
      w  = 8'($urandom);
      a0 = ack_stamps.size();
      exp_q.push_back(w);
      data_in    = w;
      data_valid = 1'b1;
      wait_acks(a0 + 1, "random");
      data_valid = 1'b0;
      for (int g = 0; g < 200 && busy_out; g++) begin
        status_in = ($urandom_range(0, 3) == 0);
        tick();
      end
      status_in = 1'b0;
      wait_idle("random");
    end
    tick();
    vectors += 2;
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL random_pending: got %0d want 0", exp_q.size());
    end
    if (word_count !== 8'd20) begin
      miscompares++; $display("FAIL random_count: got %0d want 20", word_count);
    end
  endtask

  // Continue streaming until 256 words since reset: counter wraps to zero.
  task automatic test_wrap();
    int a0;
    a0 = ack_stamps.size();
    data_in = 8'd20;
    exp_q.push_back(8'd20);
    data_valid = 1'b1;
    for (int i = 20; i < 256; i++) begin
      wait_acks(a0 + i - 19, "wrap");
      if (i < 255) begin
        data_in = 8'(i + 1);
        exp_q.push_back(8'(i + 1));
      end else begin
        data_valid = 1'b0;
      end
    end
    wait_idle("wrap");
    tick();
    vectors += 2;
    if (word_count !== 8'd0) begin
      miscompares++; $display("FAIL wrap_count: got %0d want 0", word_count);
    end
    if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL wrap_pending: got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_word();
    test_stall();
    test_back_to_back();
    test_reset_midword();
    test_random_loopback();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
